ifu_fetch: RTL and testbench

- Instruction fetch unit on the consumer side of the PC/next-PC interface.
- Holds the architectural PC and issues one read per instruction to instruction memory over a valid/ready request/response channel.
- Delivers the fetched instruction, its PC and a fault code to decode over a valid/ready handshake.
- Waits for a commit pulse carrying the next PC before starting the next fetch, so at most one fetch is in flight.

---
 rtl/ifu_fetch_pkg.sv | 33 +++
 rtl/ifu_timeout_cnt.sv | 41 ++++
 rtl/ifu_fetch.sv | 164 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit. Other core blocks
//   (decode, trap logic) import this to interpret fetch fault codes.
//   Contents:
//     fetch_state_e    - 2-bit fetch FSM state encoding
//     FETCH_*          - fault codes delivered alongside each instruction
//     INST_NOP         - canonical NOP (addi x0,x0,0) used for faulted fetches
//     RESET_PC_DEFAULT - default architectural reset vector
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // driving the memory read request
        ST_WAIT = 2'd1,   // request accepted, awaiting the response
        ST_OUT  = 2'd2,   // presenting the instruction to decode
        ST_EXEC = 2'd3    // instruction handed off, awaiting commit
    } fetch_state_e;

    localparam logic [1:0] FETCH_OK       = 2'd0;
    localparam logic [1:0] FETCH_MISALIGN = 2'd1;
    localparam logic [1:0] FETCH_ACCESS   = 2'd2;
    localparam logic [1:0] FETCH_TIMEOUT  = 2'd3;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Instructions are word aligned; any set low bit is a misaligned fetch.
    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ifu_timeout_cnt
//   Counts cycles spent waiting for an instruction memory response.
//   Ports:
//     clk     - core clock
//     rst     - synchronous active-low reset
//     clr     - restart count from zero (takes priority over en)
//     en      - count this cycle
//     expired - count has reached TIMEOUT
//   The count freezes once expired so it can never wrap back to a small value
//   if the owner lingers for a cycle.
// ---------------------------------------------------------------------------
module ifu_timeout_cnt
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit. Holds the architectural PC, issues one memory read
//   per instruction, hands the result to decode and then waits for the commit
//   pulse carrying the next PC. At most one fetch is ever in flight.
//   Ports:
//     clk, rst             - core clock, synchronous active-low reset
//     commit_valid/next_pc - retirement pulse and the PC to fetch next
//     imem_req_*           - read request channel (valid/ready, address)
//     imem_resp_*          - read response channel (valid/ready, data, err)
//     inst_valid/inst_ready- handshake to decode
//     inst, inst_pc        - instruction word and its PC
//     inst_fault           - FETCH_OK / MISALIGN / ACCESS / TIMEOUT
//   Every output is a register except imem_resp_ready, decoded from state.
// ---------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned            TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    output logic                  imem_resp_ready,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [1:0]            inst_fault
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(INST_NOP);

    fetch_state_e          state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, pc_nx;
    logic                  req_valid_nx;
    logic [ADDR_WIDTH-1:0] req_addr_nx;
    logic                  inst_valid_nx;
    logic [DATA_WIDTH-1:0] inst_nx;
    logic [ADDR_WIDTH-1:0] inst_pc_nx;
    logic [1:0]            fault_nx;
    logic                  cnt_clr, cnt_en, cnt_expired;

    ifu_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // Response channel is only open while a request is outstanding, so any
    // stray response in another state is simply never accepted.
    assign imem_resp_ready = (state == ST_WAIT);

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        req_valid_nx  = imem_req_valid;
        req_addr_nx   = imem_req_addr;
        inst_valid_nx = inst_valid;
        inst_nx       = inst;
        inst_pc_nx    = inst_pc;
        fault_nx      = inst_fault;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        unique case (state)
            ST_REQ: begin
                if (is_misaligned(pc[1:0])) begin
                    // Never touch memory for a misaligned PC; deliver a NOP
                    // tagged with the fault so the core can trap on it.
                    state_nx      = ST_OUT;
                    req_valid_nx  = 1'b0;
                    inst_valid_nx = 1'b1;
                    inst_nx       = NOP;
                    inst_pc_nx    = pc;
                    fault_nx      = FETCH_MISALIGN;
                end else if (imem_req_valid && imem_req_ready) begin
                    state_nx     = ST_WAIT;
                    req_valid_nx = 1'b0;
                    cnt_clr      = 1'b1;
                end else begin
                    // Covers the first cycle out of reset, where the request
                    // register still holds its reset value of 0.
                    req_valid_nx = 1'b1;
                end
            end

            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_nx      = ST_OUT;
                    inst_valid_nx = 1'b1;
                    inst_nx       = imem_resp_data;
                    inst_pc_nx    = pc;
                    fault_nx      = imem_resp_err ? FETCH_ACCESS : FETCH_OK;
                end else if (cnt_expired) begin
                    state_nx      = ST_OUT;
                    inst_valid_nx = 1'b1;
                    inst_nx       = NOP;
                    inst_pc_nx    = pc;
                    fault_nx      = FETCH_TIMEOUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_OUT: begin
                if (inst_ready) begin
                    state_nx      = ST_EXEC;
                    inst_valid_nx = 1'b0;
                end
            end

            ST_EXEC: begin
                if (commit_valid) begin
                    // next_pc is taken verbatim; the request is pre-armed so it
                    // is visible the cycle after commit, unless misaligned.
                    state_nx     = ST_REQ;
                    pc_nx        = next_pc;
                    req_addr_nx  = next_pc;
                    req_valid_nx = !is_misaligned(next_pc[1:0]);
                end
            end

            default: state_nx = ST_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_fault     <= FETCH_OK;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            imem_req_valid <= req_valid_nx;
            imem_req_addr  <= req_addr_nx;
            inst_valid     <= inst_valid_nx;
            inst           <= inst_nx;
            inst_pc        <= inst_pc_nx;
            inst_fault     <= fault_nx;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
//   Directed bench for ifu_fetch with a transaction-level reference model:
//   expected instructions sit in a queue, the model tracks the PC the core
//   should fetch next, whether a request is owed, whether a read is
//   outstanding and how long it has waited. A small memory responder answers
//   requests with a configurable delay, error flag or no answer at all.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] next_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;

    always #5 clk = ~clk;

    ifu_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RPC),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .commit_valid    (commit_valid),
        .next_pc         (next_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == RPC) ? 32'h0000_0297 : {a[23:0], 8'h13};
    endfunction

    // ---------------- memory responder ----------------
    int   mem_delay = 0;
    logic mem_err   = 1'b0;
    logic mem_drop  = 1'b0;

    initial begin : memory
        logic        s_req_hs, s_resp_hs, s_rst, pend;
        logic [31:0] s_addr, p_addr;
        int          cnt;
        pend = 1'b0; cnt = 0; p_addr = '0;
        forever begin
            @(negedge clk);
            s_req_hs  = imem_req_valid && imem_req_ready;
            s_resp_hs = imem_resp_valid && imem_resp_ready;
            s_rst     = rst;
            s_addr    = imem_req_addr;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                pend = 1'b0;
                imem_resp_valid = 1'b0;
            end else begin
                if (s_resp_hs) imem_resp_valid = 1'b0;
                if (s_req_hs) begin
                    pend = !mem_drop; cnt = mem_delay; p_addr = s_addr;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_data(p_addr);
                        imem_resp_err   = mem_err;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t        q[$];
    logic        m_started = 1'b0, m_in_rst = 1'b0;
    logic [31:0] m_pc = RPC;
    logic        m_need_fetch = 1'b0, m_outstanding = 1'b0;
    logic        m_awaiting = 1'b0, m_mis_pend = 1'b0;
    int          m_wait = 0;

    always @(negedge clk) begin
        // Compare DUT state produced by the last posedge against the model.
        if (m_started) begin
            if (m_in_rst) begin
                check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                check("rst_req_addr",  imem_req_addr, RPC);
                check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
                check("rst_inst", inst, 32'd0);
                check("rst_inst_pc", inst_pc, 32'd0);
                check("rst_fault", {30'b0, inst_fault}, 32'd0);
            end else begin
                check("req_valid", {31'b0, imem_req_valid}, {31'b0, m_need_fetch});
                if (m_need_fetch) check("req_addr", imem_req_addr, m_pc);
                check("resp_ready", {31'b0, imem_resp_ready}, {31'b0, m_outstanding});
                check("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
                if (q.size() != 0) begin
                    check("inst", inst, q[0].word);
                    check("inst_pc", inst_pc, q[0].pc);
                    check("inst_fault", {30'b0, inst_fault}, {30'b0, q[0].fault});
                end
            end
        end
        // Advance the model over the coming posedge using current inputs.
        if (!rst) begin
            m_started = 1'b1; m_in_rst = 1'b1;
            q.delete();
            m_pc = RPC; m_need_fetch = 1'b0; m_outstanding = 1'b0;
            m_awaiting = 1'b0; m_mis_pend = 1'b0; m_wait = 0;
        end else if (m_started) begin
            if (m_in_rst) begin
                m_in_rst = 1'b0;
                m_need_fetch = 1'b1;
            end else begin
                if (m_mis_pend) begin
                    q.push_back('{NOPW, m_pc, 2'd1});
                    m_mis_pend = 1'b0;
                end
                if (commit_valid) begin
                    if (m_awaiting) begin
                        m_awaiting = 1'b0;
                        m_pc = next_pc;
                        if (next_pc[1:0] == 2'b00) m_need_fetch = 1'b1;
                        else                       m_mis_pend   = 1'b1;
                    end else begin
                        $display("[TB] note: protocol error, commit while no instruction awaits commit (t=%0t)", $time);
                    end
                end
                if (inst_valid && inst_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    m_awaiting = 1'b1;
                end
                if (m_outstanding) begin
                    if (imem_resp_valid) begin
                        q.push_back('{imem_resp_data, m_pc, imem_resp_err ? 2'd2 : 2'd0});
                        m_outstanding = 1'b0;
                    end else begin
                        m_wait++;
                        if (m_wait == TO + 1) begin
                            q.push_back('{NOPW, m_pc, 2'd3});
                            m_outstanding = 1'b0;
                        end
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    m_outstanding = 1'b1; m_wait = 0; m_need_fetch = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_inst(input string nm, input int budget);
        int i;
        i = 0;
        while (!inst_valid && i < budget) begin
            tick(1);
            i++;
        end
        check({nm, "_inst_arrives"}, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic take_inst();
        inst_ready = 1'b1;
        tick(1);
        inst_ready = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        next_pc      = pc;
        tick(1);
        commit_valid = 1'b0;
    endtask

    initial begin : stim
        logic seen;
        // Reset and first fetch: request in cycle 1, instruction in cycle 3.
        tick(3);
        check("t1_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("t1_rst_addr", imem_req_addr, 32'h8000_0000);
        rst = 1'b1;
        tick(1);
        check("t1_c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t1_c1_req_addr", imem_req_addr, 32'h8000_0000);
        tick(1);
        check("t1_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("t1_c2_inst_valid", {31'b0, inst_valid}, 32'd0);
        tick(1);
        check("t1_c3_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t1_c3_inst", inst, 32'h0000_0297);
        check("t1_c3_inst_pc", inst_pc, 32'h8000_0000);
        check("t1_c3_fault", {30'b0, inst_fault}, 32'd0);

        // Decode stalls for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t2_stall_valid", {31'b0, inst_valid}, 32'd1);
            check("t2_stall_inst", inst, 32'h0000_0297);
        end
        // Commit coinciding with the handshake must be ignored.
        inst_ready = 1'b1; commit_valid = 1'b1; next_pc = 32'h8000_0100;
        tick(1);
        inst_ready = 1'b0; commit_valid = 1'b0;
        check("t3_after_hs_valid", {31'b0, inst_valid}, 32'd0);
        tick(1);
        check("t3_exec_no_req", {31'b0, imem_req_valid}, 32'd0);

        // Commit in EXEC, then request backpressure for 5 cycles.
        imem_req_ready = 1'b0;
        commit(32'h8000_0010);
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h8000_0010);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t4_bp_valid", {31'b0, imem_req_valid}, 32'd1);
            check("t4_bp_addr", imem_req_addr, 32'h8000_0010);
        end
        mem_delay = 2;
        imem_req_ready = 1'b1;
        tick(1);
        commit(32'hDEAD_BEEC);   // during WAIT: no effect
        wait_inst("t5", 20);
        check("t5_inst", inst, 32'h0000_1013);
        check("t5_inst_pc", inst_pc, 32'h8000_0010);
        check("t5_fault", {30'b0, inst_fault}, 32'd0);
        take_inst();

        // Misaligned PC: no request, NOP with fault 1.
        mem_delay = 0;
        commit(32'h8000_0006);
        check("t6_no_req", {31'b0, imem_req_valid}, 32'd0);
        wait_inst("t6", 5);
        check("t6_inst", inst, 32'h0000_0013);
        check("t6_inst_pc", inst_pc, 32'h8000_0006);
        check("t6_fault", {30'b0, inst_fault}, 32'd1);
        take_inst();

        // Access error response.
        mem_err = 1'b1;
        commit(32'h8000_0020);
        wait_inst("t7", 10);
        check("t7_inst", inst, 32'h0000_2013);
        check("t7_fault", {30'b0, inst_fault}, 32'd2);
        take_inst();
        mem_err = 1'b0;

        // No response at all: timeout.
        mem_drop = 1'b1;
        commit(32'h8000_0030);
        wait_inst("t8", 3 * TO + 10);
        check("t8_inst", inst, 32'h0000_0013);
        check("t8_inst_pc", inst_pc, 32'h8000_0030);
        check("t8_fault", {30'b0, inst_fault}, 32'd3);
        take_inst();
        mem_drop = 1'b0;

        // Reset while WAIT: pending response is lost, fetch restarts at RESET_PC.
        mem_delay = 3;
        commit(32'h8000_0040);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (imem_req_valid && imem_req_ready) seen = 1'b1;
            tick(1);
        end
        check("t9_req_handshake", {31'b0, seen}, 32'd1);
        rst = 1'b0;
        tick(2);
        mem_delay = 0;
        rst = 1'b1;
        tick(1);
        check("t9_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t9_req_addr", imem_req_addr, 32'h8000_0000);
        check("t9_inst_valid", {31'b0, inst_valid}, 32'd0);
        wait_inst("t9", 10);
        check("t9_inst", inst, 32'h0000_0297);
        check("t9_inst_pc", inst_pc, 32'h8000_0000);
        take_inst();
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
